// File: rtl/weight_bank_ctrl.sv
// weight_bank_ctrl: streams a weight tile bank-major into NB banks and sweeps their read addresses for compute.
module weight_bank_ctrl #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int Tn = 16,
  parameter int Tm = 16,
  parameter int K  = 3,
  parameter int X  = 4,
  parameter int Y  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] wr_data,
  output logic [X*Y-1:0] wr_ena,
  output logic          load_done,
  input  logic          comp_start,
  input  logic          comp_hold,
  output logic [AW-1:0] rd_addr,
  output logic          rd_data_valid,
  output logic          comp_done,
  output logic          busy
);
  localparam int NB  = X * Y;
  localparam int CAP = (Tn / Y) * (Tm / X) * K * K;
  localparam int CW  = CAP > 1 ? $clog2(CAP) : 1;
  localparam int BW  = NB > 1 ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  state_t state, state_n;

  logic [CW-1:0] word_cnt;
  logic [BW-1:0] bank_idx;
  logic [1:0]    vld_pipe;
  logic          accept, rd, word_wrap, last_word, last_addr;

  assign accept        = in_valid && state == LOAD;
  assign word_wrap     = word_cnt == CW'(CAP - 1);
  assign last_word     = word_wrap && bank_idx == BW'(NB - 1);
  assign rd            = state == COMPUTE && !comp_hold;
  assign last_addr     = rd_addr == AW'(CAP - 1);
  assign in_ready      = state == LOAD;
  assign busy          = state != IDLE;
  assign rd_data_valid = vld_pipe[1];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = load_start ? LOAD : comp_start ? COMPUTE : IDLE;
      LOAD:    state_n = accept && last_word ? IDLE : LOAD;
      COMPUTE: state_n = rd && last_addr ? DRAIN : COMPUTE;
      DRAIN:   state_n = vld_pipe[0] ? DRAIN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;

  // Bank-major write sequencing; each bank counts its own addresses from wr_ena.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word_cnt  <= '0;
      bank_idx  <= '0;
      wr_ena    <= '0;
      wr_data   <= '0;
      load_done <= 1'b0;
    end else begin
      word_cnt  <= accept ? (word_wrap ? '0 : word_cnt + 1'b1) : word_cnt;
      bank_idx  <= accept && word_wrap ? (last_word ? '0 : bank_idx + 1'b1) : bank_idx;
      wr_ena    <= accept ? NB'(1) << bank_idx : '0;
      wr_data   <= accept ? in_data : wr_data;
      load_done <= accept && last_word;
    end

  // Two-stage valid pipe mirrors the bank's registered address and registered output.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_addr   <= '0;
      vld_pipe  <= '0;
      comp_done <= 1'b0;
    end else begin
      rd_addr   <= rd ? (last_addr ? '0 : rd_addr + 1'b1) : rd_addr;
      vld_pipe  <= {vld_pipe[0], rd};
      comp_done <= state == DRAIN && !vld_pipe[0];
    end
endmodule

// File: tb/tb_weight_bank_ctrl.sv
// tb_weight_bank_ctrl: randomized scenarios checked against a bank-major / delayed-valid reference model.
module tb_weight_bank_ctrl;
  localparam int AW = 10, DW = 32, NB = 16, CAP = 144, TOTAL = NB * CAP;

  logic clk = 0, rst = 1;
  logic load_start = 0, in_valid = 0, comp_start = 0, comp_hold = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, load_done, rd_data_valid, comp_done, busy;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_ena;
  logic [AW-1:0] rd_addr;
  int tests = 0, failed = 0;

  weight_bank_ctrl #(.AW(AW), .DW(DW), .Tn(16), .Tm(16), .K(3), .X(4), .Y(4)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_data(wr_data), .wr_ena(wr_ena), .load_done(load_done),
    .comp_start(comp_start), .comp_hold(comp_hold), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .comp_done(comp_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    tick();
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests++; if (wr_ena !== '0) begin failed++; $display("FAIL reset_wr_ena: got %h want 0", wr_ena); end
    tests++; if (wr_data !== '0) begin failed++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    tests++; if (rd_addr !== '0) begin failed++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    tests++; if ({load_done, comp_done, rd_data_valid} !== 3'b000) begin failed++; $display("FAIL reset_pulses: got %b want 000", {load_done, comp_done, rd_data_valid}); end
    rst = 0;
    tick();
  endtask

  // mode: 0 continuous (data = word index), 1 toggling valid, 2 random valid
  task automatic run_load(input string name, input int mode, input bit both, input bit noise);
    int n = 0, cyc = 0, bad = 0;
    int cnt[NB];
    string first = "none";
    logic v, rdy;
    logic [DW-1:0] d;
    logic [NB-1:0] e;
    foreach (cnt[b]) cnt[b] = 0;
    load_start = 1; comp_start = both; in_valid = 0;
    tick();
    load_start = 0; comp_start = 0;
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL %s_enter: in_ready %b want 1", name, in_ready); end
    while (n < TOTAL && cyc < 20000) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      d = mode == 0 ? DW'(n) : DW'($urandom);
      in_valid = v; in_data = d;
      comp_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      rdy = in_ready;
      tick();
      e = v ? NB'(1) << (n / CAP) : '0;
      if (rdy !== 1'b1 || wr_ena !== e || (v && wr_data !== d) || load_done !== 1'(v && n == TOTAL - 1)) begin
        if (bad == 0) first = $sformatf("word %0d cyc %0d: ena %h/%h data %h/%h done %b rdy %b", n, cyc, wr_ena, e, wr_data, d, load_done, rdy);
        bad++;
      end
      for (int b = 0; b < NB; b++) if (wr_ena[b] === 1'b1) cnt[b]++;
      if (v) n++;
      cyc++;
    end
    in_valid = 0; comp_start = 0;
    tests++; if (bad != 0 || n != TOTAL) begin failed++; $display("FAIL %s_map: %0d bad cycles, %0d/%0d words, first %s", name, bad, n, TOTAL, first); end
    bad = 0;
    foreach (cnt[b]) if (cnt[b] != CAP) bad++;
    tests++; if (bad != 0) begin failed++; $display("FAIL %s_counts: %0d banks off, bank0 %0d bank15 %0d want %0d", name, bad, cnt[0], cnt[NB-1], CAP); end
    tests++; if ({busy, in_ready} !== 2'b00) begin failed++; $display("FAIL %s_idle: busy/in_ready %b want 00", name, {busy, in_ready}); end
    if (noise) begin
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (busy !== 1'b0 || rd_data_valid !== 1'b0) bad++;
      end
      tests++; if (bad != 0) begin failed++; $display("FAIL %s_no_compute: %0d busy cycles want 0", name, bad); end
    end
  endtask

  // mode: 0 no hold, 1 three-cycle hold at address 50, 2 random hold
  task automatic run_comp(input string name, input int mode);
    int strobe[2048];
    int issued = 0, c = 0, last = -10, hcnt = 0, bad = 0, nval = 0, ndone = 0;
    string first = "none";
    bit h, st, ev, ed, ended = 0;
    comp_start = 1;
    tick();
    comp_start = 0;
    while (c < 2000 && !ended) begin
      h = mode == 1 ? (issued == 50 && hcnt < 3) : mode == 2 ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (h) hcnt++;
      comp_hold = h;
      st = issued < CAP && !h;
      strobe[c] = int'(st);
      ev = c >= 2 ? strobe[c-2] != 0 : 1'b0;
      ed = last >= 0 && c == last + 3;
      if ((issued < CAP && rd_addr !== AW'(issued)) || rd_data_valid !== ev || comp_done !== ed) begin
        if (bad == 0) first = $sformatf("cyc %0d: addr %0d/%0d valid %b/%b done %b/%b", c, rd_addr, issued, rd_data_valid, ev, comp_done, ed);
        bad++;
      end
      if (rd_data_valid === 1'b1) nval++;
      if (comp_done === 1'b1) ndone++;
      if (st) begin issued++; if (issued == CAP) last = c; end
      if (ed) ended = 1;
      else begin tick(); c++; end
    end
    comp_hold = 0;
    tests++; if (bad != 0) begin failed++; $display("FAIL %s_seq: %0d bad cycles, first %s", name, bad, first); end
    tests++; if (nval != CAP) begin failed++; $display("FAIL %s_valids: got %0d want %0d", name, nval, CAP); end
    tests++; if (ndone != 1) begin failed++; $display("FAIL %s_done: got %0d pulses want 1", name, ndone); end
    tests++; if (busy !== 1'b0 || rd_addr !== '0) begin failed++; $display("FAIL %s_end: busy %b addr %0d want 0 0", name, busy, rd_addr); end
  endtask

  task automatic test_load_abort;
    int bad = 0;
    load_start = 1;
    tick();
    load_start = 0;
    in_valid = 1;
    for (int i = 0; i < 700; i++) begin in_data = DW'($urandom); tick(); end
    #2 rst = 1;
    #1;
    tests++; if (wr_ena !== '0 || busy !== 1'b0) begin failed++; $display("FAIL load_abort_async: ena %h busy %b want 0 0", wr_ena, busy); end
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wr_ena !== '0 || busy !== 1'b0 || load_done !== 1'b0) bad++;
    end
    in_valid = 0;
    tests++; if (bad != 0) begin failed++; $display("FAIL load_abort_quiet: %0d active cycles want 0", bad); end
    run_load("load_after_rst", 0, 0, 0);
  endtask

  task automatic test_comp_abort;
    int bad = 0;
    comp_start = 1;
    tick();
    comp_start = 0;
    for (int i = 0; i < 20; i++) tick();
    #2 rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd_data_valid !== 1'b0 || rd_addr !== '0 || comp_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin failed++; $display("FAIL comp_abort_quiet: %0d active cycles want 0", bad); end
    run_comp("comp_after_rst", 0);
  endtask

  initial begin
    test_reset();
    run_load("load_cont", 0, 0, 0);
    run_load("load_toggle", 1, 0, 0);
    run_load("load_random", 2, 0, 0);
    run_comp("comp_nohold", 0);
    run_comp("comp_hold50", 1);
    run_comp("comp_random", 2);
    run_load("load_both_start", 2, 1, 1);
    test_load_abort();
    test_comp_abort();
    run_load("load_back_to_back", 0, 0, 0);
    run_comp("comp_back_to_back", 2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/weight_bank_ctrl.md
WEIGHT_BANK_CTRL -- requirements
Module: weight_bank_ctrl

Interface
REQ-001 Parameter AW, default 10, weight bank address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameters Tn, Tm, K, X, Y, defaults 16, 16, 3, 4, 4: output-channel tile, input-channel tile, kernel size, input-fm bank count, output-fm bank count.
REQ-004 Derived constants: NB = X*Y, the bank count (16 by default); CAP = (Tn/Y)*(Tm/X)*K*K, the words per bank (144 by default).
REQ-005 clk  in  1  clock; reset rst, asynchronous, active-high; clock clk.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 load_start  in  1  one-cycle request to load one weight tile.
REQ-008 in_data  in  DW  streamed weight word.
REQ-009 in_valid  in  1  in_data valid.
REQ-010 in_ready  out  1  controller accepts in_data.
REQ-011 wr_data  out  DW  write data, broadcast to all banks.
REQ-012 wr_ena  out  NB  one-hot per-bank write enable.
REQ-013 load_done  out  1  one-cycle pulse: tile fully written.
REQ-014 comp_start  in  1  one-cycle request to sweep the read addresses.
REQ-015 comp_hold  in  1  stall of the read sweep.
REQ-016 rd_addr  out  AW  read address, broadcast to all banks.
REQ-017 rd_data_valid  out  1  bank rd_data is valid this cycle.
REQ-018 comp_done  out  1  one-cycle pulse: sweep complete, all data delivered.
REQ-019 busy  out  1  high when the state is not IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, COMPUTE and DRAIN, with one state active at a time.
REQ-021 From IDLE:
- load_start moves the FSM to LOAD.
- Otherwise comp_start moves the FSM to COMPUTE.
- If both are asserted, load_start SHALL win and comp_start SHALL be dropped.
REQ-022 load_start and comp_start SHALL be ignored outside IDLE.
REQ-023 in_ready SHALL equal (state==LOAD).
REQ-024 A word is accepted when in_valid and in_ready are both high.
REQ-025 Words SHALL be accepted bank-major:
- Counter word_cnt runs 0..CAP-1.
- Counter bank_idx runs 0..NB-1.
- word_cnt wraps to 0 after CAP-1 and then increments bank_idx.
REQ-026 One cycle after an accept, wr_data SHALL equal the accepted word and wr_ena SHALL be one-hot at the accepted word's bank_idx; otherwise wr_ena SHALL be all zeros (registered, latency 1).
REQ-027 The bank addresses itself with its own wr_ena-driven counter; the controller SHALL emit exactly CAP enables per bank per load.
REQ-028 Final word of a load (bank_idx==NB-1, word_cnt==CAP-1):
- On its accept, the FSM SHALL go to IDLE and both counters SHALL clear.
- load_done SHALL pulse in the same cycle as the final wr_ena.
REQ-029 In COMPUTE, rd_addr SHALL start at 0 and increment by 1 on each cycle with comp_hold low.
REQ-030 In COMPUTE, the read strobe SHALL be (state==COMPUTE)&&!comp_hold; this internal strobe feeds the valid pipeline.
REQ-031 When the read strobe is high with rd_addr==CAP-1:
- The FSM SHALL go to DRAIN.
- rd_addr SHALL return to 0.
REQ-032 rd_data_valid SHALL be the read strobe delayed by exactly 2 cycles, matching the bank's registered address plus registered output.
REQ-033 DRAIN SHALL last until the valid pipeline is empty (2 cycles). comp_done SHALL pulse on the cycle after the last rd_data_valid, and the FSM SHALL then return to IDLE.
REQ-034 comp_hold SHALL freeze rd_addr and the read strobe. rd_data_valid SHALL still drain already-issued reads.
REQ-035 A load with in_valid low on some cycles SHALL only pause the counters; no words are lost or duplicated.

Reset
REQ-036 On rst the following SHALL clear asynchronously: state=IDLE, word_cnt=0, bank_idx=0, rd_addr=0, wr_ena=0, wr_data=0, valid pipeline=0, load_done=0, comp_done=0, busy=0, in_ready=0.
REQ-037 rst during LOAD or COMPUTE SHALL abort the operation with no further wr_ena or rd_data_valid.
REQ-038 A new load after such a reset SHALL start at bank 0, word 0.

Verification
REQ-039 Load with continuous in_valid, words 0..2303:
- Exactly 144 wr_ena pulses per bank.
- wr_ena[0] carries words 0..143 and wr_ena[15] carries words 2160..2303.
- load_done coincides with the wr_ena[15] carrying word 2303.
REQ-040 Load with in_valid toggling 1-0 each cycle: same bank/word mapping as REQ-039; load_done at cycle ~4608 after start.
REQ-041 comp_start, no hold: rd_addr runs 0..143 on 144 consecutive cycles; rd_data_valid is high 144 cycles starting 2 cycles later; comp_done follows the last rd_data_valid by 1 cycle.
REQ-042 comp_hold high for 3 cycles at rd_addr=50: rd_addr holds 50; rd_data_valid shows a matching 3-cycle gap; total 144 valids.
REQ-043 load_start and comp_start asserted together in IDLE: LOAD is entered; comp_start asserted during LOAD is ignored, so there is no COMPUTE after load_done.
REQ-044 rst at word 700 of a load, then a new load: the first post-reset wr_ena is wr_ena[0] and the full 2304-word mapping is correct.
